// File: rtl/branch_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_if
//   Bundles the signals between the pipeline and the branch resolve unit.
//   Fetch side : f_pc (lookup address) -> f_guess (predicted direction)
//   MEM side   : m_is_branch, m_is_jalr, m_branch_taken, m_guess, m_pc,
//                m_jb_addr -> flush, redirect_en, redirect_pc
//   Modports:
//     master - pipeline side; drives f_pc and m_*, receives the results
//     slave  - branch resolve unit; receives f_pc and m_*, drives the results
// ---------------------------------------------------------------------------
interface branch_resolve_unit_if;
    logic [31:0] f_pc;
    logic        f_guess;
    logic        m_is_branch;
    logic        m_is_jalr;
    logic        m_branch_taken;
    logic        m_guess;
    logic [31:0] m_pc;
    logic [31:0] m_jb_addr;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;

    modport master (
        output f_pc, m_is_branch, m_is_jalr, m_branch_taken, m_guess, m_pc, m_jb_addr,
        input  f_guess, flush, redirect_en, redirect_pc
    );

    modport slave (
        input  f_pc, m_is_branch, m_is_jalr, m_branch_taken, m_guess, m_pc, m_jb_addr,
        output f_guess, flush, redirect_en, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves conditional branches and JALRs in MEM, raises flush/redirect on
//   a mispredict, and trains a table of 2-bit saturating direction counters
//   that also feeds the predicted direction back to fetch.
//
//   Ports:
//     clk          - clock, all state updates on the rising edge
//     rst          - synchronous, active-high reset
//     bus          - branch_resolve_unit_if.slave (fetch lookup + MEM resolve)
//     perf_br_cnt  - (BRU_PERF_CNT_EN only) resolved conditional branches
//     perf_mis_cnt - (BRU_PERF_CNT_EN only) mispredicts incl. every JALR
//
//   Optional feature macro: BRU_PERF_CNT_EN adds the two performance counters.
//
//   Parameters:
//     IDX_W    - log2 of the predictor table depth
//     INIT_CNT - counter value loaded on reset (weakly not-taken)
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave bus
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_br_cnt,
    output logic [31:0]          perf_mis_cnt
`endif
);
    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0][1:0] cnt_tbl;
    logic [IDX_W-1:0]      f_idx;
    logic [IDX_W-1:0]      m_idx;
    logic [1:0]            cnt_cur;
    logic [1:0]            cnt_nxt;
    logic                  mis_br;
    logic                  mis_jr;
    logic                  redir;
    logic                  train;
    logic [31:0]           rpc;

    // Word-aligned index; byte offset and upper PC bits do not take part.
    assign f_idx = bus.f_pc[IDX_W+1:2];
    assign m_idx = bus.m_pc[IDX_W+1:2];

    logic unused_f_pc;
    assign unused_f_pc = ^{bus.f_pc[31:IDX_W+2], bus.f_pc[1:0]};

    assign mis_br = bus.m_is_branch & (bus.m_branch_taken ^ bus.m_guess);
    assign mis_jr = bus.m_is_jalr;
    assign redir  = (mis_br | mis_jr) & ~rst;
    // Branch+JALR together is illegal; JALR wins and the table is left alone.
    assign train  = bus.m_is_branch & ~bus.m_is_jalr;

    always_comb begin
        rpc = 32'd0;
        if (!rst) begin
            if (mis_jr)
                rpc = bus.m_jb_addr & 32'hFFFF_FFFE;
            else if (mis_br)
                rpc = bus.m_branch_taken ? bus.m_jb_addr : bus.m_pc + 32'd4;
        end
    end

    assign bus.flush       = redir;
    assign bus.redirect_en = redir;
    assign bus.redirect_pc = rpc;
    // Reads the registered table, so a same-cycle update is not yet visible.
    assign bus.f_guess     = rst ? INIT_CNT[1] : cnt_tbl[f_idx][1];

    // Saturating up/down step of the entry being trained.
    assign cnt_cur = cnt_tbl[m_idx];
    always_comb begin
        cnt_nxt = cnt_cur;
        if (bus.m_branch_taken) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) cnt_tbl[i] <= INIT_CNT;
        end else if (train) begin
            cnt_tbl[m_idx] <= cnt_nxt;
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_cnt  <= 32'd0;
            perf_mis_cnt <= 32'd0;
        end else begin
            if (train) perf_br_cnt  <= perf_br_cnt + 32'd1;
            if (redir) perf_mis_cnt <= perf_mis_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Scoreboard bench: each driven cycle pushes its expected flush/redirect/
//   f_guess (from a small model of the counter table) and a negedge monitor
//   pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_unit_if bus();

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mis_cnt;
    logic [31:0] br_cnt_m;
    logic [31:0] mis_cnt_m;
`endif

    branch_resolve_unit #(.IDX_W(6), .INIT_CNT(2'b01)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_br_cnt  (perf_br_cnt),
        .perf_mis_cnt (perf_mis_cnt)
`endif
    );

    typedef struct {
        string       name;
        logic        flush;
        logic        redirect_en;
        logic [31:0] redirect_pc;
        logic        f_guess;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [1:0]  model [64];
    int          errors = 0;
    int          checks = 0;
    string       cur_name = "init";

    // Scoreboard monitor: compares every driven cycle away from the edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            checks += 4;
            if (bus.flush !== mon_e.flush) begin
                errors++;
                $display("FAIL %s flush got=%0b exp=%0b", mon_e.name, bus.flush, mon_e.flush);
            end
            if (bus.redirect_en !== mon_e.redirect_en) begin
                errors++;
                $display("FAIL %s redirect_en got=%0b exp=%0b", mon_e.name, bus.redirect_en, mon_e.redirect_en);
            end
            if (bus.redirect_pc !== mon_e.redirect_pc) begin
                errors++;
                $display("FAIL %s redirect_pc got=%h exp=%h", mon_e.name, bus.redirect_pc, mon_e.redirect_pc);
            end
            if (bus.f_guess !== mon_e.f_guess) begin
                errors++;
                $display("FAIL %s f_guess got=%0b exp=%0b", mon_e.name, bus.f_guess, mon_e.f_guess);
            end
        end
    end

    // One clock cycle of stimulus: apply inputs, queue expectation, advance
    // the model on the rising edge, return 1 time unit after it.
    task automatic drive(input logic r, input logic br, input logic jr, input logic tk,
                         input logic gs, input logic [31:0] mpc, input logic [31:0] jb,
                         input logic [31:0] fpc);
        exp_t e;
        logic mb;
        rst                = r;
        bus.m_is_branch    = br;
        bus.m_is_jalr      = jr;
        bus.m_branch_taken = tk;
        bus.m_guess        = gs;
        bus.m_pc           = mpc;
        bus.m_jb_addr      = jb;
        bus.f_pc           = fpc;
        mb = br & (tk != gs);
        e.name = cur_name;
        if (r) begin
            e.flush = 1'b0; e.redirect_en = 1'b0; e.redirect_pc = 32'd0; e.f_guess = 1'b0;
        end else begin
            e.flush       = mb | jr;
            e.redirect_en = mb | jr;
            if (jr)      e.redirect_pc = jb & 32'hFFFF_FFFE;
            else if (mb) e.redirect_pc = tk ? jb : mpc + 32'd4;
            else         e.redirect_pc = 32'd0;
            e.f_guess = model[fpc[7:2]][1];
        end
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 64; i++) model[i] = 2'b01;
`ifdef BRU_PERF_CNT_EN
            br_cnt_m = 0; mis_cnt_m = 0;
`endif
        end else begin
            if (br && !jr) begin
                if (tk) model[mpc[7:2]] = (model[mpc[7:2]] == 2'b11) ? 2'b11 : model[mpc[7:2]] + 2'd1;
                else    model[mpc[7:2]] = (model[mpc[7:2]] == 2'b00) ? 2'b00 : model[mpc[7:2]] - 2'd1;
`ifdef BRU_PERF_CNT_EN
                br_cnt_m++;
`endif
            end
`ifdef BRU_PERF_CNT_EN
            if (mb || jr) mis_cnt_m++;
`endif
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] fpc);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, fpc);
    endtask

    task automatic test_reset();
        cur_name = "reset";
        // Outputs forced quiet under reset even with a JALR presented.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h301, 32'h100);
        checks++;
        if (bus.flush !== 1'b0 || bus.redirect_pc !== 32'd0 || bus.f_guess !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold flush=%0b pc=%h guess=%0b exp 0/0/0", bus.flush, bus.redirect_pc, bus.f_guess);
        end
        cur_name = "reset_lookup";
        idle(32'h100);
        // Train a few entries, then reset with a pending update.
        cur_name = "reset_mid";
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'h200, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'h100);
        cur_name = "reset_sweep";
        for (int i = 0; i < 64; i++) idle(32'(i) << 2);
    endtask

    task automatic test_mispredict();
        cur_name = "mispredict_taken";
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'h100);
        cur_name = "mispredict_after";
        idle(32'h100);
        checks++;
        if (bus.f_guess !== 1'b1) begin
            errors++;
            $display("FAIL mispredict_weakT f_guess got=%0b exp=1", bus.f_guess);
        end
    endtask

    task automatic test_saturate();
        cur_name = "saturate_up";
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 32'h100);
        cur_name = "saturate_nt";
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h200, 32'h100);
        checks++;
        if (bus.redirect_pc !== 32'h104) begin
            errors++;
            $display("FAIL saturate_nt redirect_pc got=%h exp=00000104", bus.redirect_pc);
        end
        cur_name = "saturate_after";
        idle(32'h100);
        checks++;
        if (bus.f_guess !== 1'b1) begin
            errors++;
            $display("FAIL saturate_weakT f_guess got=%0b exp=1", bus.f_guess);
        end
    endtask

    task automatic test_jalr();
        cur_name = "jalr";
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h301, 32'h100);
        checks++;
        if (bus.redirect_pc !== 32'h300) begin
            errors++;
            $display("FAIL jalr redirect_pc got=%h exp=00000300", bus.redirect_pc);
        end
        cur_name = "jalr_and_branch";
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h555, 32'h100);
        cur_name = "jalr_after";
        idle(32'h100);
        checks++;
        if (bus.f_guess !== 1'b1) begin
            errors++;
            $display("FAIL jalr_table_unchanged f_guess got=%0b exp=1", bus.f_guess);
        end
    endtask

    task automatic test_correct_wrap();
        cur_name = "correct_pred";
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 32'h100);
        cur_name = "wrap_pc4";
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234, 32'hFFFF_FFFC);
        checks++;
        if (bus.redirect_en !== 1'b1 || bus.redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc4 en=%0b pc=%h exp 1/00000000", bus.redirect_en, bus.redirect_pc);
        end
        cur_name = "bubble";
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200, 32'h100);
    endtask

    task automatic test_alias();
        cur_name = "alias_nt";
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h100);
        cur_name = "alias_rbw";
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h80, 32'h100);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h80, 32'h100);
        cur_name = "alias_after";
        idle(32'h100);
        checks++;
        if (bus.f_guess !== 1'b1) begin
            errors++;
            $display("FAIL alias_after f_guess got=%0b exp=1", bus.f_guess);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [4];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200; pcs[3] = 32'h3FC;
        cur_name = "b2b_random";
        for (int i = 0; i < 60; i++) begin
            logic br, jr;
            br = ($urandom_range(0, 3) != 0);
            jr = ($urandom_range(0, 7) == 0);
            drive(1'b0, br, jr, 1'($urandom), 1'($urandom), pcs[$urandom_range(0, 3)],
                  $urandom, pcs[$urandom_range(0, 3)]);
        end
    endtask

`ifdef BRU_PERF_CNT_EN
    task automatic test_perf();
        checks += 2;
        if (perf_br_cnt !== br_cnt_m) begin
            errors++;
            $display("FAIL perf_br_cnt got=%0d exp=%0d", perf_br_cnt, br_cnt_m);
        end
        if (perf_mis_cnt !== mis_cnt_m) begin
            errors++;
            $display("FAIL perf_mis_cnt got=%0d exp=%0d", perf_mis_cnt, mis_cnt_m);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) model[i] = 2'b01;
`ifdef BRU_PERF_CNT_EN
        br_cnt_m = 0; mis_cnt_m = 0;
`endif
        rst = 1'b1;
        bus.m_is_branch = 1'b0; bus.m_is_jalr = 1'b0; bus.m_branch_taken = 1'b0;
        bus.m_guess = 1'b0; bus.m_pc = 32'h0; bus.m_jb_addr = 32'h0; bus.f_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_mispredict();
        test_saturate();
        test_jalr();
        test_correct_wrap();
        test_alias();
        test_back_to_back();
`ifdef BRU_PERF_CNT_EN
        test_perf();
`endif
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer side of the execute/memory branch-resolution fields. Reads the registered branch outcome, prediction bit, target and PC at the start of MEM.
- Decides mispredict, generates pipeline flush and fetch redirect, and trains a table of 2-bit saturating direction predictors.
- The same table also supplies the `guess` bit to the fetch stage, closing the predict/resolve loop.

Parameters:
- IDX_W, 6, log2 of predictor table depth (64 entries).
- INIT_CNT, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- f_pc  input  32  fetch-stage PC used for lookup
- f_guess  output  1  predicted direction for f_pc (counter MSB)
- m_is_branch  input  1  conditional branch in MEM (already flush-qualified)
- m_is_jalr  input  1  JALR in MEM
- m_branch_taken  input  1  resolved direction
- m_guess  input  1  direction predicted when this instruction was fetched
- m_pc  input  32  PC of the MEM instruction
- m_jb_addr  input  32  resolved branch/JALR target
- flush  output  1  kill IF/ID and ID/EX contents this cycle
- redirect_en  output  1  fetch must load redirect_pc next edge
- redirect_pc  output  32  corrected fetch address

Behaviour:
- Table: 2^IDX_W entries x 2 bits, indexed by pc[IDX_W+1:2]. Byte offset bits [1:0] are ignored.
- Lookup is combinational:
  - f_guess = table[f_pc idx][1].
  - Same-cycle read of an index being updated returns the old value (read-before-write).
- Mispredict, evaluated combinationally from the m_* inputs:
  - mis_br = m_is_branch & (m_branch_taken != m_guess).
  - mis_jr = m_is_jalr (JALR is never predicted, so it always redirects).
  - flush = redirect_en = mis_br | mis_jr.
- redirect_pc selection:
  - m_is_jalr: m_jb_addr & 32'hFFFF_FFFE.
  - mis_br and taken: m_jb_addr.
  - mis_br and not taken: m_pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - no redirect: 32'b0.
- Precedence: m_is_branch and m_is_jalr both high is illegal. The JALR rule wins and the table is not updated.
- Training, on the clock edge when m_is_branch=1 and m_is_jalr=0:
  - Taken: counter += 1, saturating at 2'b11.
  - Not taken: counter -= 1, saturating at 2'b00.
  - Training happens whether or not the prediction was correct.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. f_guess = 1 in states 10 and 11.
- Reset:
  - Every entry is set to INIT_CNT on the rst edge.
  - While rst=1, flush=0, redirect_en=0, redirect_pc=0 and f_guess=INIT_CNT[1], regardless of inputs.
  - Reset asserted mid-stream discards any pending update in that cycle.
- Latency:
  - flush and redirect: 0 cycles from the m_* inputs.
  - Table update: visible to f_guess from the cycle after the edge.
- Back-to-back branches to the same index in consecutive cycles: each applies its own update in order, with no lost increments.
- m_* inputs with m_is_branch=0 and m_is_jalr=0 (a bubble or a flushed slot): no update, no redirect.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined: adds outputs perf_br_cnt[31:0] and perf_mis_cnt[31:0].
  - perf_br_cnt increments per resolved conditional branch.
  - perf_mis_cnt increments per mis_br or mis_jr.
  - Both wrap at 2^32, are cleared by rst, and update on the same edge as training.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then f_pc=0x100 -> f_guess=0. Assert rst mid-training -> all entries read back 01.
2. m_is_branch=1, m_pc=0x100, taken=1, guess=0, jb_addr=0x200 -> flush=1, redirect_pc=0x200 same cycle. Next cycle f_pc=0x100 gives f_guess=1 (01->10).
3. Four taken updates at 0x100 -> counter saturates at 11. Then one not-taken with guess=1 -> flush=1, redirect_pc=0x104, f_guess stays 1 (11->10).
4. m_is_jalr=1, m_jb_addr=0x301 -> flush=1, redirect_pc=0x300, table unchanged.
5. Correct prediction (taken=1, guess=1) -> flush=0, redirect_pc=0. Not-taken mispredict at m_pc=0xFFFF_FFFC -> redirect_pc=0x0.
6. Aliasing: updates to 0x100 and 0x200 with IDX_W=6 hit the same entry. Update at the lookup index in the same cycle -> f_guess shows the old value, then the new value next cycle. With BRU_PERF_CNT_EN defined, perf counters match the counted branches and mispredicts.
